// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - UART-side and CPU-side signal bundle for the receive FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        pop;
  logic        clear_overrun;
  logic [7:0]  dout;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        overrun;

  modport master (
    output rx_valid, rx_data, pop, clear_overrun,
    input  rx_rd, dout, count, empty, full, overrun
  );

  modport slave (
    input  rx_valid, rx_data, pop, clear_overrun,
    output rx_rd, dout, count, empty, full, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - Receive FIFO draining the UART into a CPU-readable registered output.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = $clog2(DEPTH),
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic           clk,
  input  logic           reset_button,
  uart_rx_fifo_if.slave  bus
);
  typedef enum logic {IDLE, ACK} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          empty;
  logic          full;
  logic          rx_rd;
  logic          overrun;
  logic [7:0]    dout;
  logic          space;
  logic          push;
  logic          drop;
  logic          take;

  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  always_comb begin
    space = !full || bus.pop;
    push  = (state == IDLE) && bus.rx_valid && space;
    drop  = DROP_ON_FULL && (state == IDLE) && bus.rx_valid && !space;
    take  = bus.pop && !empty;
    count_next = count;
    case ({push, take})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      state   <= IDLE;
      rx_rd   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      dout    <= 8'h00;
      overrun <= 1'b0;
    end else begin
      // ACK covers the cycle in which the UART is still dropping valid after rd.
      case (state)
        IDLE: begin
          if (push || drop) begin
            rx_rd <= 1'b1;
            state <= ACK;
          end else begin
            rx_rd <= 1'b0;
          end
        end
        ACK: begin
          rx_rd <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rx_rd <= 1'b0;
          state <= IDLE;
        end
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);

      if (take) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end else if (bus.pop) begin
        dout <= 8'h00;
      end

      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));

      if (drop) overrun <= 1'b1;
      else if (bus.clear_overrun) overrun <= 1'b0;
    end
  end

  assign bus.rx_rd   = rx_rd;
  assign bus.dout    = dout;
  assign bus.count   = count;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.overrun = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - Directed bench for uart_rx_fifo in backpressure and drop modes.
module tb_uart_rx_fifo;
  logic clk;
  logic reset_button;

  uart_rx_fifo_if #(.DEPTH(16)) b0 ();
  uart_rx_fifo_if #(.DEPTH(16)) b1 ();

  uart_rx_fifo #(.DEPTH(16), .DROP_ON_FULL(1'b0)) dut0 (
    .clk          (clk),
    .reset_button (reset_button),
    .bus          (b0)
  );

  uart_rx_fifo #(.DEPTH(16), .DROP_ON_FULL(1'b1)) dut1 (
    .clk          (clk),
    .reset_button (reset_button),
    .bus          (b1)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int rd_cnt0 = 0;
  int rd_cnt1 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART models: present the queue head, retire it when rd is seen.
  always @(negedge clk) begin
    if (b0.rx_rd === 1'b1) begin
      rd_cnt0++;
      if (q0.size() > 0) void'(q0.pop_front());
      b0.rx_valid = 1'b0;
    end else if (q0.size() > 0) begin
      b0.rx_valid = 1'b1;
      b0.rx_data  = q0[0];
    end else begin
      b0.rx_valid = 1'b0;
      b0.rx_data  = 8'h00;
    end
  end

  always @(negedge clk) begin
    if (b1.rx_rd === 1'b1) begin
      rd_cnt1++;
      if (q1.size() > 0) void'(q1.pop_front());
      b1.rx_valid = 1'b0;
    end else if (q1.size() > 0) begin
      b1.rx_valid = 1'b1;
      b1.rx_data  = q1[0];
    end else begin
      b1.rx_valid = 1'b0;
      b1.rx_data  = 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_button = 1'b0;
    q0.push_back(8'hA5);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (b0.rx_rd !== 1'b0 || b0.count !== 5'd0 || b0.empty !== 1'b1 || b0.dout !== 8'h00 || b0.full !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rd=%b count=%0d empty=%b dout=%h full=%b want rd=0 count=0 empty=1 dout=00 full=0",
               b0.rx_rd, b0.count, b0.empty, b0.dout, b0.full);
    end
    total++;
    if (b1.overrun !== 1'b0 || b1.empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_state_drop overrun=%b empty=%b want 0 1", b1.overrun, b1.empty);
    end
    reset_button = 1'b1;
    tick();
    total++;
    if (b0.rx_rd !== 1'b1 || b0.count !== 5'd1) begin
      bad++;
      $display("FAIL reset_capture rd=%b count=%0d want rd=1 count=1", b0.rx_rd, b0.count);
    end
    tick();
    total++;
    if (b0.rx_rd !== 1'b0) begin
      bad++;
      $display("FAIL reset_rd_width rd=%b want 0", b0.rx_rd);
    end
    repeat (3) tick();
    total++;
    if (rd_cnt0 !== 1 || b0.count !== 5'd1 || b0.empty !== 1'b0) begin
      bad++;
      $display("FAIL reset_one_pulse pulses=%0d count=%0d empty=%b want 1 1 0", rd_cnt0, b0.count, b0.empty);
    end
    b0.pop = 1'b1;
    tick();
    b0.pop = 1'b0;
    total++;
    if (b0.dout !== 8'hA5 || b0.empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_drain dout=%h empty=%b want a5 1", b0.dout, b0.empty);
    end
  endtask

  task automatic test_in_order();
    logic [7:0] exp [3];
    int base;
    int n;
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    base = rd_cnt0;
    for (int i = 0; i < 3; i++) q0.push_back(exp[i]);
    n = 0;
    while (rd_cnt0 < base + 3 && n < 20) begin tick(); n++; end
    tick();
    total++;
    if (b0.count !== 5'd3 || rd_cnt0 !== base + 3) begin
      bad++;
      $display("FAIL order_fill count=%0d pulses=%0d want 3 %0d", b0.count, rd_cnt0, base + 3);
    end
    b0.pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (b0.dout !== exp[i]) begin
        bad++;
        $display("FAIL order_dout%0d dout=%h want %h", i, b0.dout, exp[i]);
      end
    end
    b0.pop = 1'b0;
    tick();
    total++;
    if (b0.empty !== 1'b1 || b0.count !== 5'd0) begin
      bad++;
      $display("FAIL order_empty empty=%b count=%0d want 1 0", b0.empty, b0.count);
    end
    b0.pop = 1'b1;
    tick();
    b0.pop = 1'b0;
    total++;
    if (b0.dout !== 8'h00 || b0.count !== 5'd0) begin
      bad++;
      $display("FAIL order_underflow dout=%h count=%0d want 00 0", b0.dout, b0.count);
    end
  endtask

  task automatic test_fill_backpressure();
    int base;
    int n;
    base = rd_cnt0;
    for (int i = 0; i <= 16; i++) q0.push_back(8'(i));
    n = 0;
    while (b0.count !== 5'd16 && n < 80) begin tick(); n++; end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (b0.rx_rd !== 1'b0) begin
        bad++;
        $display("FAIL bp_no_rd cycle=%0d rd=%b want 0", k, b0.rx_rd);
      end
    end
    total++;
    if (b0.full !== 1'b1 || b0.count !== 5'd16 || rd_cnt0 !== base + 16 || b0.overrun !== 1'b0) begin
      bad++;
      $display("FAIL bp_full full=%b count=%0d pulses=%0d overrun=%b want 1 16 %0d 0",
               b0.full, b0.count, rd_cnt0, b0.overrun, base + 16);
    end
    b0.pop = 1'b1;
    tick();
    b0.pop = 1'b0;
    total++;
    if (b0.dout !== 8'h00 || b0.rx_rd !== 1'b1 || b0.count !== 5'd16) begin
      bad++;
      $display("FAIL bp_pop_capture dout=%h rd=%b count=%0d want 00 1 16", b0.dout, b0.rx_rd, b0.count);
    end
    tick();
    b0.pop = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++;
      if (b0.dout !== 8'(i)) begin
        bad++;
        $display("FAIL bp_drain%0d dout=%h want %h", i, b0.dout, 8'(i));
      end
    end
    b0.pop = 1'b0;
    tick();
    total++;
    if (b0.empty !== 1'b1 || rd_cnt0 !== base + 17) begin
      bad++;
      $display("FAIL bp_end empty=%b pulses=%0d want 1 %0d", b0.empty, rd_cnt0, base + 17);
    end
  endtask

  task automatic test_full_push_pop();
    int n;
    for (int i = 0; i < 16; i++) q0.push_back(8'h20 + 8'(i));
    n = 0;
    while (b0.count !== 5'd16 && n < 80) begin tick(); n++; end
    q0.push_back(8'h99);
    repeat (3) tick();
    total++;
    if (b0.rx_rd !== 1'b0 || b0.count !== 5'd16) begin
      bad++;
      $display("FAIL fpp_stall rd=%b count=%0d want 0 16", b0.rx_rd, b0.count);
    end
    b0.pop = 1'b1;
    tick();
    b0.pop = 1'b0;
    total++;
    if (b0.dout !== 8'h20 || b0.count !== 5'd16 || b0.full !== 1'b1 || b0.rx_rd !== 1'b1) begin
      bad++;
      $display("FAIL fpp_both dout=%h count=%0d full=%b rd=%b want 20 16 1 1", b0.dout, b0.count, b0.full, b0.rx_rd);
    end
    tick();
    b0.pop = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++;
      if (b0.dout !== ((i == 16) ? 8'h99 : 8'h20 + 8'(i))) begin
        bad++;
        $display("FAIL fpp_drain%0d dout=%h want %h", i, b0.dout, (i == 16) ? 8'h99 : 8'h20 + 8'(i));
      end
    end
    b0.pop = 1'b0;
    tick();
    total++;
    if (b0.empty !== 1'b1 || b0.count !== 5'd0) begin
      bad++;
      $display("FAIL fpp_end empty=%b count=%0d want 1 0", b0.empty, b0.count);
    end
  endtask

  task automatic test_drop_on_full();
    int n;
    for (int i = 0; i < 18; i++) q1.push_back(8'(i));
    n = 0;
    while (rd_cnt1 < 18 && n < 100) begin tick(); n++; end
    repeat (2) tick();
    total++;
    if (rd_cnt1 !== 18 || b1.count !== 5'd16 || b1.full !== 1'b1 || b1.overrun !== 1'b1) begin
      bad++;
      $display("FAIL drop_fill pulses=%0d count=%0d full=%b overrun=%b want 18 16 1 1",
               rd_cnt1, b1.count, b1.full, b1.overrun);
    end
    b1.pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (b1.dout !== 8'(i)) begin
        bad++;
        $display("FAIL drop_drain%0d dout=%h want %h", i, b1.dout, 8'(i));
      end
    end
    b1.pop = 1'b0;
    tick();
    total++;
    if (b1.overrun !== 1'b1 || b1.empty !== 1'b1) begin
      bad++;
      $display("FAIL drop_sticky overrun=%b empty=%b want 1 1", b1.overrun, b1.empty);
    end
    b1.clear_overrun = 1'b1;
    tick();
    b1.clear_overrun = 1'b0;
    total++;
    if (b1.overrun !== 1'b0) begin
      bad++;
      $display("FAIL drop_clear overrun=%b want 0", b1.overrun);
    end
  endtask

  task automatic test_wrap();
    int base;
    int n;
    logic [7:0] v;
    base = rd_cnt0;
    for (int i = 0; i < 40; i++) begin
      v = 8'(i * 3);
      q0.push_back(v);
      n = 0;
      while (rd_cnt0 <= base + i && n < 10) begin tick(); n++; end
      total++;
      if (rd_cnt0 <= base + i || b0.count !== 5'd1) begin
        bad++;
        $display("FAIL wrap_push%0d pulses=%0d count=%0d want %0d 1", i, rd_cnt0, b0.count, base + i + 1);
      end
      b0.pop = 1'b1;
      tick();
      b0.pop = 1'b0;
      total++;
      if (b0.dout !== v || b0.count !== 5'd0) begin
        bad++;
        $display("FAIL wrap_pop%0d dout=%h count=%0d want %h 0", i, b0.dout, b0.count, v);
      end
    end
  endtask

  initial begin
    b0.pop = 1'b0;
    b0.clear_overrun = 1'b0;
    b1.pop = 1'b0;
    b1.clear_overrun = 1'b0;
    test_reset();
    test_in_order();
    test_fill_backpressure();
    test_full_push_pop();
    test_drop_on_full();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between the buart receiver and the CPU IO read path.
- Drains each byte the UART flags as valid into a small FIFO and acknowledges the UART with a one-cycle rd pulse.
- Presents bytes to the CPU in order on a registered output, one cycle after a pop strobe. This matches the IO read timing, where data is sampled one cycle after the read strobe.
- Exports count, empty, full and a sticky overrun flag for the UART status register.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, $clog2(DEPTH), pointer width.
- DROP_ON_FULL, 0: 0 = hold the byte in the UART while full (backpressure); 1 = acknowledge and discard it, setting overrun.

Ports:
- clk  input  1  system clock (50 MHz).
- reset_button  input  1  reset, asynchronous, active-low.
- rx_valid  input  1  UART has a received byte pending.
- rx_data  input  8  received byte; stable while rx_valid is high.
- rx_rd  output  1  one-cycle acknowledge to the UART rd input.
- pop  input  1  CPU read strobe for the data register.
- clear_overrun  input  1  clears the sticky overrun flag.
- dout  output  8  popped byte, registered.
- count  output  AW+1  current occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overrun  output  1  sticky: a byte was discarded.

Behaviour:
- Reset (reset_button low, asynchronous):
  - rd_ptr = wr_ptr = 0, count = 0, dout = 0, rx_rd = 0, overrun = 0, state = IDLE.
  - empty = 1, full = 0.
  - Storage contents are don't-care.
- Write-side FSM, states IDLE and ACK:
  - IDLE, rx_valid = 1, and space available → write rx_data at wr_ptr, wr_ptr++, rx_rd = 1 next cycle, go to ACK.
    - Space available means !full, or full with pop asserted in the same cycle.
  - IDLE, rx_valid = 1, no space, DROP_ON_FULL = 0 → no write, no rx_rd, stay in IDLE. The byte stays pending in the UART.
  - IDLE, rx_valid = 1, no space, DROP_ON_FULL = 1 → no write, rx_rd = 1, overrun <= 1, go to ACK.
  - ACK: rx_rd = 0 and rx_valid is ignored for this one cycle, because the UART clears valid on the cycle after rd. Return to IDLE unconditionally.
  - Maximum intake is therefore one byte per two cycles, far faster than the line rate.
  - rx_rd is registered and is exactly one cycle wide.
- Read side:
  - pop with !empty → dout <= mem[rd_ptr], rd_ptr++ on the next clock edge. dout is valid the cycle after pop.
  - pop with empty → dout <= 8'h00; pointers and count unchanged; no error flag.
  - dout holds its value when pop is low.
- Count:
  - +1 on write only, −1 on pop-with-data only, unchanged when both or neither happen.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - Empty FIFO: only the push takes effect; the pop returns 00 and count becomes 1.
  - Full FIFO: both take effect; count stays DEPTH; dout gets the old head; the new byte is written into the freed slot.
- Overrun:
  - Sets only in DROP_ON_FULL mode.
  - clear_overrun clears it; a simultaneous set wins.
  - Unaffected by pop.
- Status: empty, full and count are registered and consistent with each other every cycle.
- Reset mid-operation: an in-flight rx_rd pulse is aborted (rx_rd = 0 immediately) and the FSM returns to IDLE. A UART byte left pending is captured after reset releases.

Test Plan:
- Reset: assert reset_button low for 3 cycles with rx_valid = 1 → rx_rd = 0, count = 0, empty = 1, dout = 00. After release the byte is captured, count = 1, and exactly one rx_rd pulse occurs.
- In-order: push 0x41, 0x42, 0x43 (valid dropping the cycle after each rd), then pop three times → dout = 41, 42, 43 on the cycle after each pop; empty = 1 at the end; a fourth pop gives dout = 00 with count still 0.
- Fill with DROP_ON_FULL = 0: push 17 bytes 0x00..0x10 → full = 1, count = 16, and rx_valid stays high with no rx_rd. One pop → dout = 00, and 0x10 is captured within 2 cycles.
- Fill with DROP_ON_FULL = 1: push 18 bytes → count = 16, overrun = 1, rx_rd is pulsed 18 times, and pops return 0x00..0x0F. clear_overrun → overrun = 0.
- Full with simultaneous push and pop: at count = 16, pop while rx_valid = 0x99 → count stays 16, dout = old head. After 16 more pops the last byte returned is 99.
- Wrap-around: 40 interleaved push/pop pairs with values i*3 → every dout matches its push, count never exceeds 2, and pointers wrap with no corruption.
